// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Optional build macro used by this block: SEG_SCAN_LEADING_ZERO_BLANK_EN.
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] ANODES_OFF = 8'hFF;

    function automatic int idxWidth(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Digit k >= 1 is suppressed while it and every higher digit are zero.
    function automatic logic [7:0] leadingZeroMask(input logic [31:0] data, input int digits);
        logic       allZero;
        logic [7:0] mask;
        allZero = 1'b1;
        mask    = 8'h00;
        for (int k = 7; k >= 1; k--) begin
            if (k < digits) begin
                allZero = allZero && (data[4*k +: 4] == 4'h0);
                mask[k] = allZero;
            end else begin
                mask[k] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Control/data bundle between a host and seg_scan_driver.
// The master side feeds data and enable; the slave side drives decoder and anodes.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   data_i;
    logic [DIGITS-1:0]     point_i;
    logic [DIGITS-1:0]     blank_i;
    logic [3:0]            hex_o;
    logic                  le_o;
    logic                  point_o;
    logic [DIGITS-1:0]     an_o;
    logic                  pend_o;
    logic                  frame_o;

    modport master (
        output en, load, data_i, point_i, blank_i,
        input  hex_o, le_o, point_o, an_o, pend_o, frame_o
    );

    modport slave (
        input  en, load, data_i, point_i, blank_i,
        output hex_o, le_o, point_o, an_o, pend_o, frame_o
    );
endinterface

// File: rtl/seg_scan_prescaler.sv
// Digit-slot timer: counts 0..TICK_DIV-1 while enabled and flags the
// last blanked cycle and the last cycle of each slot.
module seg_scan_prescaler #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic slotEnd_s,
    output logic blankEnd_s
);
    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_r;

    // Slot counter; holds its value while the scan is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CW'(TICK_DIV - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign slotEnd_s  = en && (cnt_r == CW'(TICK_DIV - 1));
    assign blankEnd_s = en && (cnt_r == CW'(BLANK_CYC - 1));

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed digit scanner feeding a hex-to-7-segment decoder.
// Define SEG_SCAN_LEADING_ZERO_BLANK_EN to dark leading zero digits.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);
    localparam int IW = idxWidth(DIGITS);
    localparam logic [DIGITS-1:0] ANODES_ALL_OFF = ANODES_OFF[DIGITS-1:0];

    scan_state_t          state_r, stateNext_s;
    logic [IW-1:0]        idx_r, idxNext_s;
    logic [4*DIGITS-1:0]  activeData_r, pendData_r, activeDataNext_s;
    logic [DIGITS-1:0]    activePoint_r, pendPoint_r, activePointNext_s;
    logic [DIGITS-1:0]    activeBlank_r, pendBlank_r, activeBlankNext_s;
    logic [DIGITS-1:0]    lzMaskNext_s, blankEff_s, anNext_s, an_r;
    logic                 pend_r, slotEnd_s, blankEnd_s, commit_s, dark_s;
    logic                 leNext_s, pointNext_s, le_r, point_r, frame_r;
    logic [3:0]           hexNext_s, hex_r;

    seg_scan_prescaler #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .slotEnd_s  (slotEnd_s),
        .blankEnd_s (blankEnd_s)
    );

    assign commit_s          = slotEnd_s && (idx_r == IW'(DIGITS - 1));
    assign activeDataNext_s  = (commit_s && pend_r) ? pendData_r  : activeData_r;
    assign activePointNext_s = (commit_s && pend_r) ? pendPoint_r : activePoint_r;
    assign activeBlankNext_s = (commit_s && pend_r) ? pendBlank_r : activeBlank_r;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lzMask_r;
    logic [7:0]        lzFull_s;

    assign lzFull_s     = leadingZeroMask(32'(pendData_r), DIGITS);
    assign lzMaskNext_s = (commit_s && pend_r) ? lzFull_s[DIGITS-1:0] : lzMask_r;

    // Suppression mask follows the active data, refreshed only at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzMask_r <= '0;
        end else begin
            lzMask_r <= lzMaskNext_s;
        end
    end
`else
    assign lzMaskNext_s = '0;
`endif

    assign blankEff_s = activeBlankNext_s | lzMaskNext_s;

    // Next FSM state and digit index.
    always_comb begin
        stateNext_s = state_r;
        idxNext_s   = idx_r;
        case (state_r)
            BLANK:   if (blankEnd_s) stateNext_s = SHOW;  else stateNext_s = BLANK;
            SHOW:    if (slotEnd_s)  stateNext_s = BLANK; else stateNext_s = SHOW;
            default: stateNext_s = BLANK;
        endcase
        if (slotEnd_s) begin
            idxNext_s = (idx_r == IW'(DIGITS - 1)) ? IW'(0) : idx_r + IW'(1);
        end else begin
            idxNext_s = idx_r;
        end
    end

    // Outputs are decoded from next-cycle state so the registers line up with it.
    always_comb begin
        dark_s      = !bus.en || (stateNext_s == BLANK) || blankEff_s[idxNext_s];
        hexNext_s   = activeDataNext_s[4*idxNext_s +: 4];
        anNext_s    = ANODES_ALL_OFF;
        leNext_s    = 1'b1;
        pointNext_s = 1'b0;
        if (dark_s) begin
            anNext_s    = ANODES_ALL_OFF;
            leNext_s    = 1'b1;
            pointNext_s = 1'b0;
        end else begin
            anNext_s    = ANODES_ALL_OFF & ~(DIGITS'(1) << idxNext_s);
            leNext_s    = 1'b0;
            pointNext_s = activePointNext_s[idxNext_s];
        end
    end

    // Scan state, active and pending data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BLANK;
            idx_r         <= '0;
            activeData_r  <= '0;
            activePoint_r <= '0;
            activeBlank_r <= '0;
            pendData_r    <= '0;
            pendPoint_r   <= '0;
            pendBlank_r   <= '0;
            pend_r        <= 1'b0;
        end else begin
            state_r       <= stateNext_s;
            idx_r         <= idxNext_s;
            activeData_r  <= activeDataNext_s;
            activePoint_r <= activePointNext_s;
            activeBlank_r <= activeBlankNext_s;
            if (bus.load) begin
                pendData_r  <= bus.data_i;
                pendPoint_r <= bus.point_i;
                pendBlank_r <= bus.blank_i;
                pend_r      <= 1'b1;
            end else if (commit_s) begin
                pend_r      <= 1'b0;
            end
        end
    end

    // Registered decoder and anode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r    <= ANODES_ALL_OFF;
            le_r    <= 1'b1;
            hex_r   <= 4'h0;
            point_r <= 1'b0;
            frame_r <= 1'b0;
        end else begin
            an_r    <= anNext_s;
            le_r    <= leNext_s;
            hex_r   <= hexNext_s;
            point_r <= pointNext_s;
            frame_r <= commit_s;
        end
    end

    assign bus.an_o    = an_r;
    assign bus.le_o    = le_r;
    assign bus.hex_o   = hex_r;
    assign bus.point_o = point_r;
    assign bus.pend_o  = pend_r;
    assign bus.frame_o = frame_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed table-driven bench for seg_scan_driver (DIGITS=4, TICK_DIV=8, BLANK_CYC=2).
// Expectations adapt to SEG_SCAN_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_scan_driver;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg_scan_driver_if #(.DIGITS(4)) bus ();

    seg_scan_driver #(
        .DIGITS    (4),
        .TICK_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       name;
        logic        en;
        logic        load;
        logic [15:0] data;
        logic [3:0]  point;
        logic [3:0]  blank;
        int          adv;
        logic [3:0]  an;
        logic        le;
        logic [3:0]  hex;
        logic        pt;
        logic        pend;
        logic        frame;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic en, input logic load,
                                input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                                input int adv, input logic [3:0] an, input logic le,
                                input logic [3:0] hex, input logic pt, input logic pend,
                                input logic frame);
        vec_t v;
        v.name = n; v.en = en; v.load = load; v.data = d; v.point = p; v.blank = b;
        v.adv = adv; v.an = an; v.le = le; v.hex = hex; v.pt = pt; v.pend = pend;
        v.frame = frame;
        return v;
    endfunction

    task automatic checkOut(input string n, input logic [3:0] an, input logic le,
                            input logic [3:0] hex, input logic pt, input logic pend,
                            input logic frame);
        logic [11:0] got, want;
        got  = {bus.an_o, bus.le_o, bus.hex_o, bus.point_o, bus.pend_o, bus.frame_o};
        want = {an, le, hex, pt, pend, frame};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got an=%h le=%b hex=%h pt=%b pend=%b frame=%b, want an=%h le=%b hex=%h pt=%b pend=%b frame=%b",
                     n, bus.an_o, bus.le_o, bus.hex_o, bus.point_o, bus.pend_o, bus.frame_o,
                     an, le, hex, pt, pend, frame);
        end
    endtask

    task automatic runVec(input vec_t v);
        bus.en      = v.en;
        bus.load    = v.load;
        bus.data_i  = v.data;
        bus.point_i = v.point;
        bus.blank_i = v.blank;
        for (int i = 0; i < v.adv; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.load = 1'b0;
        end
        checkOut(v.name, v.an, v.le, v.hex, v.pt, v.pend, v.frame);
    endtask

    initial begin
        bus.en = 1'b1; bus.load = 1'b0; bus.data_i = 16'h0000;
        bus.point_i = 4'h0; bus.blank_i = 4'h0;

        // Reset asserted in the middle of a SHOW phase, with data pending.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOut("reset_idle", 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        bus.load = 1'b1; bus.data_i = 16'h1A2F;
        @(posedge clk); @(negedge clk);
        bus.load = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checkOut("pre_reset_show", 4'hE, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOut("reset_async", 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOut("reset_release", 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

        // Positions in comments: cycles since release (slot = pos/8 mod 4, count = pos mod 8).
        vecs.push_back(mk("a_load_p1",     1,1,16'h1A2F,4'b0100,4'h0, 1, 4'hF,1,4'h0,0,1,0));
        vecs.push_back(mk("a_show0_p2",    1,0,16'h0,4'h0,4'h0,       1, 4'hE,0,4'h0,0,1,0));
        vecs.push_back(mk("a_commit_p32",  1,0,16'h0,4'h0,4'h0,      30, 4'hF,1,4'hF,0,0,1));
        vecs.push_back(mk("a_blank_p33",   1,0,16'h0,4'h0,4'h0,       1, 4'hF,1,4'hF,0,0,0));
        vecs.push_back(mk("a_slot0_p34",   1,0,16'h0,4'h0,4'h0,       1, 4'hE,0,4'hF,0,0,0));
        vecs.push_back(mk("a_slot0_p39",   1,0,16'h0,4'h0,4'h0,       5, 4'hE,0,4'hF,0,0,0));
        vecs.push_back(mk("a_slot1b_p40",  1,0,16'h0,4'h0,4'h0,       1, 4'hF,1,4'h2,0,0,0));
        vecs.push_back(mk("a_slot1_p42",   1,0,16'h0,4'h0,4'h0,       2, 4'hD,0,4'h2,0,0,0));
        vecs.push_back(mk("a_slot2_p50",   1,0,16'h0,4'h0,4'h0,       8, 4'hB,0,4'hA,1,0,0));
        vecs.push_back(mk("a_slot3_p58",   1,0,16'h0,4'h0,4'h0,       8, 4'h7,0,4'h1,0,0,0));
        vecs.push_back(mk("a_frame_p64",   1,0,16'h0,4'h0,4'h0,       6, 4'hF,1,4'hF,0,0,1));
        vecs.push_back(mk("a_frame_p65",   1,0,16'h0,4'h0,4'h0,       1, 4'hF,1,4'hF,0,0,0));
        vecs.push_back(mk("b_slot1_p74",   1,0,16'h0,4'h0,4'h0,       9, 4'hD,0,4'h2,0,0,0));
        vecs.push_back(mk("b_load_p75",    1,1,16'h5555,4'h0,4'h0,    1, 4'hD,0,4'h2,0,1,0));
        vecs.push_back(mk("b_old2_p83",    1,0,16'h0,4'h0,4'h0,       8, 4'hB,0,4'hA,1,1,0));
        vecs.push_back(mk("b_old3_p91",    1,0,16'h0,4'h0,4'h0,       8, 4'h7,0,4'h1,0,1,0));
        vecs.push_back(mk("b_commit_p96",  1,0,16'h0,4'h0,4'h0,       5, 4'hF,1,4'h5,0,0,1));
        vecs.push_back(mk("b_new0_p98",    1,0,16'h0,4'h0,4'h0,       2, 4'hE,0,4'h5,0,0,0));
        vecs.push_back(mk("c_load_p99",    1,1,16'h9876,4'h0,4'b1000, 1, 4'hE,0,4'h5,0,1,0));
        vecs.push_back(mk("c_slot3_p127",  1,0,16'h0,4'h0,4'h0,      28, 4'h7,0,4'h5,0,1,0));
        vecs.push_back(mk("c_coload_p128", 1,1,16'h3333,4'h0,4'h0,    1, 4'hF,1,4'h6,0,1,1));
        vecs.push_back(mk("c_slot0_p130",  1,0,16'h0,4'h0,4'h0,       2, 4'hE,0,4'h6,0,1,0));
        vecs.push_back(mk("c_slot1_p142",  1,0,16'h0,4'h0,4'h0,      12, 4'hD,0,4'h7,0,1,0));
        vecs.push_back(mk("c_slot2_p150",  1,0,16'h0,4'h0,4'h0,       8, 4'hB,0,4'h8,0,1,0));
        vecs.push_back(mk("c_slot3b_p152", 1,0,16'h0,4'h0,4'h0,       2, 4'hF,1,4'h9,0,1,0));
        vecs.push_back(mk("c_dark3_p154",  1,0,16'h0,4'h0,4'h0,       2, 4'hF,1,4'h9,0,1,0));
        vecs.push_back(mk("c_dark3_p159",  1,0,16'h0,4'h0,4'h0,       5, 4'hF,1,4'h9,0,1,0));
        vecs.push_back(mk("c_commit_p160", 1,0,16'h0,4'h0,4'h0,       1, 4'hF,1,4'h3,0,0,1));
        vecs.push_back(mk("c_slot0_p162",  1,0,16'h0,4'h0,4'h0,       2, 4'hE,0,4'h3,0,0,0));
        vecs.push_back(mk("d_slot2_p181",  1,0,16'h0,4'h0,4'h0,      19, 4'hB,0,4'h3,0,0,0));
        vecs.push_back(mk("d_freeze",      0,1,16'h0040,4'b0100,4'h0, 1, 4'hF,1,4'h3,0,1,0));
        vecs.push_back(mk("d_frozen",      0,0,16'h0,4'h0,4'h0,      19, 4'hF,1,4'h3,0,1,0));
        vecs.push_back(mk("d_resume_p182", 1,0,16'h0,4'h0,4'h0,       1, 4'hB,0,4'h3,0,1,0));
        vecs.push_back(mk("d_resume_p183", 1,0,16'h0,4'h0,4'h0,       1, 4'hB,0,4'h3,0,1,0));
        vecs.push_back(mk("d_slot3b_p184", 1,0,16'h0,4'h0,4'h0,       1, 4'hF,1,4'h3,0,1,0));
        vecs.push_back(mk("d_slot3_p186",  1,0,16'h0,4'h0,4'h0,       2, 4'h7,0,4'h3,0,1,0));
        vecs.push_back(mk("e_commit_p192", 1,0,16'h0,4'h0,4'h0,       6, 4'hF,1,4'h0,0,0,1));
        vecs.push_back(mk("e_slot0_p194",  1,0,16'h0,4'h0,4'h0,       2, 4'hE,0,4'h0,0,0,0));
        vecs.push_back(mk("e_slot1_p202",  1,0,16'h0,4'h0,4'h0,       8, 4'hD,0,4'h4,0,0,0));
        vecs.push_back(mk("e_slot2_p210",  1,0,16'h0,4'h0,4'h0,       8,
                          LZ ? 4'hF : 4'hB, LZ, 4'h0, !LZ, 0, 0));
        vecs.push_back(mk("e_slot3_p218",  1,0,16'h0,4'h0,4'h0,       8,
                          LZ ? 4'hF : 4'h7, LZ, 4'h0, 0, 0, 0));
        vecs.push_back(mk("e_load0_p219",  1,1,16'h0000,4'h0,4'h0,    1,
                          LZ ? 4'hF : 4'h7, LZ, 4'h0, 0, 1, 0));
        vecs.push_back(mk("e_zslot1_p234", 1,0,16'h0,4'h0,4'h0,      15,
                          LZ ? 4'hF : 4'hD, LZ, 4'h0, 0, 0, 0));
        vecs.push_back(mk("e_zslot2_p242", 1,0,16'h0,4'h0,4'h0,       8,
                          LZ ? 4'hF : 4'hB, LZ, 4'h0, 0, 0, 0));
        vecs.push_back(mk("e_zslot0_p258", 1,0,16'h0,4'h0,4'h0,      16, 4'hE,0,4'h0,0,0,0));

        foreach (vecs[i]) runVec(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
